// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - SPI flash to memory boot copy sequencer
//
// Copies LEN bytes from SPI flash (READ opcode + 24-bit address) into a
// byte-wide memory sink, owning the SPI engine and flash_cs_n while busy.
// Optional feature macro: FLASH_FAST_READ_EN (opcode 8'h0B plus one dummy
// byte after the address; without it the dummy state does not exist).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           one-cycle request (IDLE only), level abort
//   src_addr/dst_addr/length  transfer parameters, latched on start
//   busy, done, aborted    status (done is a one-cycle pulse, aborted sticky)
//   flash_cs_n             flash chip select, active low
//   spi_go/spi_txd         byte request to the shared SPI engine
//   spi_rxd/spi_done       byte result from the SPI engine
//   mem_we/mem_addr/mem_data/mem_ready  write port to the sink
module flash_boot_loader #(
   parameter logic [7:0] CMD_READ = 8'h03,
   parameter int         CS_SETUP = 2,
   parameter int         CS_HOLD  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [23:0] src_addr,
   input  logic [15:0] dst_addr,
   input  logic [15:0] length,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic        flash_cs_n,
   output logic        spi_go,
   output logic [7:0]  spi_txd,
   input  logic [7:0]  spi_rxd,
   input  logic        spi_done,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   input  logic        mem_ready
);

`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] OPCODE = 8'h0B;
`else
   localparam logic [7:0] OPCODE = CMD_READ;
`endif

   typedef enum logic [3:0] {
      S_IDLE, S_SETUP, S_CMD, S_A2, S_A1, S_A0,
`ifdef FLASH_FAST_READ_EN
      S_DUMMY,
`endif
      S_DATA, S_WRITE, S_HOLD
   } state_t;

   state_t      state, state_n;
   logic        sent, sent_n;      // spi_go issued for the current byte, awaiting spi_done
   logic [7:0]  cnt, cnt_n;        // CS setup / hold countdown
   logic [23:0] src;
   logic [15:0] remaining;
   logic        accept;
   logic        finish;
   logic        stop;
   state_t      after_addr;

   // An abort seen earlier (already recorded in aborted) keeps steering the
   // sequencer to HOLD even if the abort level has since dropped.
   assign stop       = abort | aborted;
   assign busy       = (state != S_IDLE);
   assign flash_cs_n = (state == S_IDLE);

   always_comb begin
      state_n    = state;
      sent_n     = sent;
      cnt_n      = cnt;
      spi_go     = 1'b0;
      spi_txd    = 8'hFF;
      mem_we     = 1'b0;
      accept     = 1'b0;
      finish     = 1'b0;
      after_addr = (remaining == 16'd0) ? S_HOLD : S_DATA;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_SETUP;
               cnt_n   = 8'(CS_SETUP);
            end
         end
         S_SETUP: begin
            if (stop)               state_n = S_HOLD;
            else if (cnt <= 8'd1)   state_n = S_CMD;
            else                    cnt_n   = cnt - 8'd1;
         end
         S_WRITE: begin
            // An abort drops the pending write: mem_we never rises.
            if (stop) begin
               state_n = S_HOLD;
            end else begin
               mem_we = 1'b1;
               if (mem_ready) begin
                  accept  = 1'b1;
                  state_n = (remaining == 16'd1) ? S_HOLD : S_DATA;
               end
            end
         end
         S_HOLD: begin
            if (cnt <= 8'd1) begin
               state_n = S_IDLE;
               finish  = 1'b1;
            end else begin
               cnt_n = cnt - 8'd1;
            end
         end
         default: begin
            // Byte-exchange states: one spi_go, then wait for spi_done.
            case (state)
               S_CMD:   spi_txd = OPCODE;
               S_A2:    spi_txd = src[23:16];
               S_A1:    spi_txd = src[15:8];
               S_A0:    spi_txd = src[7:0];
               default: spi_txd = 8'hFF;
            endcase
            if (!sent) begin
               if (stop) begin
                  state_n = S_HOLD;
               end else begin
                  spi_go = 1'b1;
                  sent_n = 1'b1;
               end
            end else if (spi_done) begin
               sent_n = 1'b0;
               if (stop) begin
                  state_n = S_HOLD;
               end else begin
                  case (state)
                     S_CMD:   state_n = S_A2;
                     S_A2:    state_n = S_A1;
                     S_A1:    state_n = S_A0;
`ifdef FLASH_FAST_READ_EN
                     S_A0:    state_n = S_DUMMY;
                     S_DUMMY: state_n = after_addr;
`else
                     S_A0:    state_n = after_addr;
`endif
                     default: state_n = S_WRITE;
                  endcase
               end
            end
         end
      endcase

      if (state_n == S_HOLD && state != S_HOLD) cnt_n = 8'(CS_HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sent      <= 1'b0;
         cnt       <= 8'd0;
         src       <= 24'd0;
         remaining <= 16'd0;
         mem_addr  <= 16'd0;
         mem_data  <= 8'd0;
         aborted   <= 1'b0;
         done      <= 1'b0;
      end else begin
         state <= state_n;
         sent  <= sent_n;
         cnt   <= cnt_n;
         done  <= finish;
         if (state == S_IDLE && start) begin
            src       <= src_addr;
            mem_addr  <= dst_addr;
            remaining <= length;
            aborted   <= 1'b0;
         end else if (abort && state != S_IDLE && state != S_HOLD) begin
            aborted <= 1'b1;
         end
         if (state == S_DATA && sent && spi_done) mem_data <= spi_rxd;
         if (accept) begin
            mem_addr  <= mem_addr + 16'd1;
            remaining <= remaining - 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb/tb_flash_boot_loader.sv - self-checking bench for flash_boot_loader
module tb_flash_boot_loader;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
`ifdef FLASH_FAST_READ_EN
   localparam logic [7:0] OPC = 8'h0B;
   localparam int         HDR = 5;
`else
   localparam logic [7:0] OPC = 8'h03;
   localparam int         HDR = 4;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [23:0] src_addr = '0;
   logic [15:0] dst_addr = '0;
   logic [15:0] length = '0;
   logic        busy, done, aborted, flash_cs_n, spi_go, mem_we;
   logic [7:0]  spi_txd, mem_data;
   logic [7:0]  spi_rxd = 8'h00;
   logic        spi_done = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_ready = 1'b1;

   flash_boot_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .busy(busy), .done(done), .aborted(aborted), .flash_cs_n(flash_cs_n),
      .spi_go(spi_go), .spi_txd(spi_txd), .spi_rxd(spi_rxd), .spi_done(spi_done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] src;
      logic [15:0] dst;
      logic [15:0] len;
      int          lat;
      int          stall;
      bit          rand_ready;
      int          abort_at;
      bit          restart;
      bit          fixed_rx;
      int          exp_tx;
      int          exp_wr;     // -1: abort case, at most two writes allowed
      bit          exp_ab;
   } vec_t;

   int errors = 0;
   int checks = 0;

   // environment state shared by the engine/sink models and the monitor
   logic [7:0]  tx_log[$];
   logic [15:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   logic [7:0]  rx_pool[64];
   int  done_cnt, go_overlap, go_during_we, stab_err, seq_err, pre_cs, post_cs, stalled;
   int  lat = 0, stall_req = 0, abort_at = -1, nrx = 0, eng_wait = 0;
   bit  rand_ready = 0, eng_busy = 0, seen_go = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_addr;
   logic [7:0]  prev_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: the byte stream a read of v must put on the wire.
   function automatic logic [7:0] model_tx(input vec_t v, input int i);
      case (i)
         0:       return OPC;
         1:       return v.src[23:16];
         2:       return v.src[15:8];
         3:       return v.src[7:0];
         default: return 8'hFF;
      endcase
   endfunction

   function automatic vec_t mk(input logic [23:0] src, input logic [15:0] dst, input logic [15:0] len,
                               input int lt, input int st, input bit rr, input int ab,
                               input bit rs, input bit fx);
      vec_t v;
      v.src = src; v.dst = dst; v.len = len; v.lat = lt; v.stall = st;
      v.rand_ready = rr; v.abort_at = ab; v.restart = rs; v.fixed_rx = fx;
      if (ab >= 0) begin
         v.exp_tx = ab + 1;
         v.exp_wr = -1;
         v.exp_ab = 1'b1;
      end else begin
         v.exp_tx = HDR + int'(len);
         v.exp_wr = int'(len);
         v.exp_ab = 1'b0;
      end
      return v;
   endfunction

   // Monitor: observes away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (spi_go) begin
            if (eng_busy) go_overlap++;
            if (mem_we) go_during_we++;
            if (flash_cs_n) seq_err++;
            tx_log.push_back(spi_txd);
            eng_busy = 1'b1;
            eng_wait = lat;
            seen_go  = 1'b1;
         end else if (!seen_go && !flash_cs_n) begin
            pre_cs++;
         end
         if (spi_done) post_cs = 0;
         else if (!flash_cs_n) post_cs++;
         if (mem_we && prev_stall && (mem_addr !== prev_addr || mem_data !== prev_data)) stab_err++;
         prev_stall = mem_we && !mem_ready;
         prev_addr  = mem_addr;
         prev_data  = mem_data;
         if (mem_we && mem_ready) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
         end
         if (mem_we && !mem_ready) stalled++;
         if (done) begin
            done_cnt++;
            if (busy || !flash_cs_n) seq_err++;
         end
      end
   end

   // SPI engine, sink and abort drivers, updated just after the active edge.
   always @(posedge clk) begin
      #1;
      spi_done = 1'b0;
      if (eng_busy) begin
         if (eng_wait == 0) begin
            spi_done = 1'b1;
            spi_rxd  = rx_pool[nrx % 64];
            nrx++;
            eng_busy = 1'b0;
         end else begin
            eng_wait--;
         end
      end
      if (!spi_done) spi_rxd = 8'($urandom);
      if (stalled >= stall_req) mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      else                      mem_ready = 1'b0;
      abort = (abort_at >= 0) && (tx_log.size() > abort_at) && (done_cnt == 0);
   end

   task automatic clear_env(input vec_t v);
      tx_log.delete(); wr_addr.delete(); wr_data.delete();
      done_cnt = 0; go_overlap = 0; go_during_we = 0; stab_err = 0; seq_err = 0;
      pre_cs = 0; post_cs = 0; stalled = 0; nrx = 0; eng_busy = 1'b0; seen_go = 1'b0;
      lat = v.lat; stall_req = v.stall; rand_ready = v.rand_ready; abort_at = v.abort_at;
      for (int i = 0; i < 64; i++) rx_pool[i] = 8'($urandom);
      if (v.fixed_rx) begin
         rx_pool[HDR] = 8'hAA; rx_pool[HDR+1] = 8'hBB; rx_pool[HDR+2] = 8'hCC;
      end
   endtask

   task automatic run_case(input vec_t v, input string tag);
      bit was_aborted;
      bit restarted;
      int cyc;
      was_aborted = aborted;
      restarted   = 1'b0;
      @(posedge clk); #1;
      clear_env(v);
      @(posedge clk); #1;
      start = 1'b1; src_addr = v.src; dst_addr = v.dst; length = v.len;
      @(posedge clk); #1;
      start = 1'b0; src_addr = 24'($urandom); dst_addr = 16'($urandom); length = 16'($urandom);
      @(negedge clk);
      check({tag, "_busy_after_start"}, busy, 1);
      if (was_aborted) check({tag, "_aborted_cleared"}, aborted, 0);
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (v.restart && !restarted && tx_log.size() == 2) begin
            start = 1'b1; restarted = 1'b1;
         end
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, done_cnt != 0, 1);
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_idle_cs"}, {busy, flash_cs_n}, 2'b01);
      check({tag, "_aborted"}, aborted, v.exp_ab);
      check({tag, "_tx_count"}, tx_log.size(), v.exp_tx);
      for (int i = 0; i < tx_log.size() && i < v.exp_tx; i++)
         check($sformatf("%s_tx%0d", tag, i), tx_log[i], model_tx(v, i));
      if (v.exp_wr >= 0) check({tag, "_wr_count"}, wr_addr.size(), v.exp_wr);
      else               check({tag, "_wr_count_le2"}, wr_addr.size() <= 2, 1);
      for (int j = 0; j < wr_addr.size() && j < int'(v.len); j++)
         check($sformatf("%s_wr%0d", tag, j), {wr_addr[j], wr_data[j]},
               {16'(v.dst + 16'(j)), rx_pool[HDR + j]});
      check({tag, "_protocol"}, {go_overlap, go_during_we, stab_err, seq_err}, 0);
      check({tag, "_cs_setup"}, pre_cs >= CS_SETUP, 1);
      check({tag, "_cs_hold"}, post_cs >= CS_HOLD, 1);
      if (v.stall > 0) check({tag, "_stalled"}, stalled >= v.stall, 1);
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0] = mk(24'h012345, 16'h8000, 16'd3, 2, 0, 0, -1, 0, 1);
      tbl[1] = mk(24'h00ABCD, 16'h1234, 16'd0, 1, 0, 0, -1, 0, 0);
      tbl[2] = mk(24'hFEDCBA, 16'hFFFF, 16'd2, 1, 5, 0, -1, 0, 0);
      tbl[3] = mk(24'h100000, 16'h0400, 16'd10, 3, 0, 0, HDR + 1, 0, 0);
      tbl[4] = mk(24'h0F0F0F, 16'h2000, 16'd1, 0, 0, 0, -1, 0, 0);
      tbl[5] = mk(24'h55AA55, 16'h7FFE, 16'd4, 2, 0, 1, -1, 1, 0);
      for (int k = 6; k < 12; k++)
         tbl[k] = mk(24'($urandom), 16'($urandom), 16'($urandom_range(0, 20)),
                     $urandom_range(0, 4), 0, 1, -1, 0, 0);

      #1 rst_n = 1'b0;
      #3;
      check("reset_outputs", {busy, done, aborted, flash_cs_n, spi_go, spi_txd, mem_we},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0});
      check("reset_mem", {mem_addr, mem_data}, 24'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      for (int k = 0; k < 12; k++) run_case(tbl[k], $sformatf("vec%0d", k));

      // asynchronous reset while the A1 address byte is in flight
      begin
         vec_t v;
         int cyc;
         v = mk(24'h234567, 16'h0100, 16'd5, 3, 0, 0, -1, 0, 0);
         @(posedge clk); #1;
         clear_env(v);
         @(posedge clk); #1;
         start = 1'b1; src_addr = v.src; dst_addr = v.dst; length = v.len;
         @(posedge clk); #1;
         start = 1'b0;
         cyc = 0;
         while (tx_log.size() < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
         check("rst_reached_a1", tx_log.size(), 3);
         #2 rst_n = 1'b0;
         #1;
         check("rst_mid_cs_busy", {flash_cs_n, busy, spi_go, mem_we, done}, 5'b10000);
         check("rst_mid_txd_mem", {spi_txd, mem_addr, mem_data}, {8'hFF, 24'd0});
         repeat (2) @(posedge clk);
         #1 eng_busy = 1'b0; rst_n = 1'b1;
         run_case(mk(24'h3C3C3C, 16'hABCD, 16'd6, 1, 0, 1, -1, 0, 0), "after_rst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
